// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch/decode status from the core into the next-PC
// sequencer, and PC-unit control plus trap status back out.
interface pc_sequencer_if #(
  parameter int CNT_W = 8
);
  logic [5:0]       opcode;
  logic             z;
  logic             inst_valid;
  logic             stall;
  logic             supervisor;
  logic             irq;
  logic [2:0]       pcsel;
  logic             pc_en;
  logic             xp_wr;
  logic             irq_ack;
  logic [CNT_W-1:0] illop_cnt;
  logic [1:0]       state_o;

  // core / PC-unit side
  modport master (
    output opcode, z, inst_valid, stall, supervisor, irq,
    input  pcsel, pc_en, xp_wr, irq_ack, illop_cnt, state_o
  );

  // sequencer side
  modport slave (
    input  opcode, z, inst_valid, stall, supervisor, irq,
    output pcsel, pc_en, xp_wr, irq_ack, illop_cnt, state_o
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC select and load-enable for the RISC core, with trap
// entry sequencing (XP write, irq handshake, fetch bubble) for interrupts and
// illegal opcodes.
//
// state | meaning
// BOOT  | post-reset hold, PC frozen for BOOT_CYCLES edges
// RUN   | normal execution, PC loads on every valid, unstalled cycle
// STALL | memory not ready, PC held; one bubble after stall drops
// TRAP  | one-cycle fetch bubble after XP was written on trap entry
module pc_sequencer #(
  parameter int CNT_W       = 8,
  parameter int BOOT_CYCLES = 2
) (
  input logic           clock,
  input logic           reset_n,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_TRAP  = 2'd3
  } state_t;

  localparam logic [2:0] PC_INC   = 3'd0;
  localparam logic [2:0] PC_BR    = 3'd1;
  localparam logic [2:0] PC_JT    = 3'd2;
  localparam logic [2:0] PC_ILLOP = 3'd3;
  localparam logic [2:0] PC_XADR  = 3'd4;

  localparam logic [3:0]       BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       boot_cnt_q;
  logic             irq_pend_q;
  logic             irq_ack_q;
  logic [CNT_W-1:0] illop_q;

  logic             legal;
  logic [2:0]       br_sel;
  logic             take_irq;
  logic             take_illop;
  logic [2:0]       pcsel_c;
  logic             pc_en_c;
  logic             xp_wr_c;

  // opcode decode: legality and branch/jump target select
  always_comb begin
    legal  = 1'b0;
    br_sel = PC_INC;
    if (bus.opcode[5]) begin
      legal = 1'b1;
    end else begin
      case (bus.opcode)
        6'h18, 6'h19, 6'h1F: legal = 1'b1;
        6'h1B: begin
          legal  = 1'b1;
          br_sel = PC_JT;
        end
        6'h1C: begin
          legal  = 1'b1;
          br_sel = bus.z ? PC_BR : PC_INC;
        end
        6'h1D: begin
          legal  = 1'b1;
          br_sel = bus.z ? PC_INC : PC_BR;
        end
        default: legal = 1'b0;
      endcase
    end
  end

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_BOOT;
    else          state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  if (boot_cnt_q == BOOT_LAST) state_d = ST_RUN;
      ST_RUN: begin
        if (bus.stall)                    state_d = ST_STALL;
        else if (take_irq || take_illop)  state_d = ST_TRAP;
      end
      ST_STALL: if (!bus.stall) state_d = ST_RUN;
      ST_TRAP:  state_d = ST_RUN;
      default:  state_d = ST_BOOT;
    endcase
  end

  // PC-unit controls; irq outranks an illegal opcode so the offender re-executes
  always_comb begin
    pcsel_c    = PC_INC;
    pc_en_c    = 1'b0;
    xp_wr_c    = 1'b0;
    take_irq   = 1'b0;
    take_illop = 1'b0;
    if (state_q == ST_RUN && !bus.stall && bus.inst_valid) begin
      pc_en_c = 1'b1;
      if (irq_pend_q && !bus.supervisor) begin
        take_irq = 1'b1;
        pcsel_c  = PC_XADR;
        xp_wr_c  = 1'b1;
      end else if (!legal) begin
        take_illop = 1'b1;
        pcsel_c    = PC_ILLOP;
        xp_wr_c    = 1'b1;
      end else begin
        pcsel_c = br_sel;
      end
    end
  end

  // boot hold counter, counts edges spent in BOOT up to its terminal value
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      boot_cnt_q <= '0;
    end else if (state_q == ST_BOOT && boot_cnt_q != BOOT_LAST) begin
      boot_cnt_q <= boot_cnt_q + 4'd1;
    end
  end

  // pending interrupt latch; taking the interrupt wins over a new request
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      irq_pend_q <= 1'b0;
    else if (take_irq) irq_pend_q <= 1'b0;
    else if (bus.irq)  irq_pend_q <= 1'b1;
  end

  // one-cycle acknowledge after the interrupt is taken
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) irq_ack_q <= 1'b0;
    else          irq_ack_q <= take_irq;
  end

  // saturating illegal-opcode trap counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      illop_q <= '0;
    end else if (take_illop && illop_q != CNT_MAX) begin
      illop_q <= illop_q + CNT_W'(1);
    end
  end

  assign bus.pcsel     = pcsel_c;
  assign bus.pc_en     = pc_en_c;
  assign bus.xp_wr     = xp_wr_c;
  assign bus.irq_ack   = irq_ack_q;
  assign bus.illop_cnt = illop_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_pc_sequencer;
  localparam int CNT_W       = 8;
  localparam int BOOT_CYCLES = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  pc_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pc_sequencer #(
    .CNT_W      (CNT_W),
    .BOOT_CYCLES(BOOT_CYCLES)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input int op);
    return (op >= 32) || op == 24 || op == 25 || op == 27 || op == 28 ||
           op == 29 || op == 31;
  endfunction

  function automatic int target_sel(input int op, input bit zz);
    if (op == 27) return 2;
    if (op == 28) return zz ? 1 : 0;
    if (op == 29) return zz ? 0 : 1;
    return 0;
  endfunction

  // model: mode 0=BOOT 1=RUN 2=STALL 3=TRAP, edges spent in boot, pending irq,
  // trap count, ack seen after the last edge
  int m_mode = 0, m_boot = 0, m_cnt = 0;
  bit m_pend = 0, m_ack = 0;
  int n_mode = 0, n_boot = 0, n_cnt = 0;
  bit n_pend = 0, n_ack = 0;

  // compare DUT against the model mid-cycle and work out the model's next step
  always @(negedge clock) begin : cmp
    int e_sel, e_en, e_xp, t_mode, t_boot, t_cnt;
    bit t_pend, t_ack;
    int op;
    e_sel = 0; e_en = 0; e_xp = 0;
    t_mode = 0; t_boot = 0; t_cnt = 0; t_pend = 0; t_ack = 0;
    op = int'(bus.opcode);
    if (reset_n) begin
      t_mode = m_mode;
      t_boot = m_boot;
      t_cnt  = m_cnt;
      t_pend = m_pend | bus.irq;
      t_ack  = 0;
      if (m_mode == 0) begin
        t_boot = m_boot + 1;
        if (t_boot >= BOOT_CYCLES) t_mode = 1;
      end else if (m_mode == 1) begin
        if (bus.stall) begin
          t_mode = 2;
        end else if (bus.inst_valid) begin
          e_en = 1;
          if (m_pend && !bus.supervisor) begin
            e_sel = 4; e_xp = 1; t_ack = 1; t_pend = 0; t_mode = 3;
          end else if (!is_legal(op)) begin
            e_sel = 3; e_xp = 1; t_mode = 3;
            t_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
          end else begin
            e_sel = target_sel(op, bus.z);
          end
        end
      end else if (m_mode == 2) begin
        if (!bus.stall) t_mode = 1;
      end else begin
        t_mode = 1;
      end
    end
    chk("m_pcsel", int'(bus.pcsel), e_sel);
    chk("m_pc_en", int'(bus.pc_en), e_en);
    chk("m_xp_wr", int'(bus.xp_wr), e_xp);
    chk("m_irq_ack", int'(bus.irq_ack), int'(m_ack));
    chk("m_illop_cnt", int'(bus.illop_cnt), m_cnt);
    chk("m_state", int'(bus.state_o), m_mode);
    n_mode <= t_mode; n_boot <= t_boot; n_cnt <= t_cnt;
    n_pend <= t_pend; n_ack <= t_ack;
  end

  // advance the model on the clock edge; reset acts immediately
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_mode <= 0; m_boot <= 0; m_cnt <= 0; m_pend <= 0; m_ack <= 0;
    end else begin
      m_mode <= n_mode; m_boot <= n_boot; m_cnt <= n_cnt;
      m_pend <= n_pend; m_ack <= n_ack;
    end
  end

  task automatic set_in(input int op, input bit zz, input bit v, input bit st,
                        input bit sup, input bit rq);
    bus.opcode     = 6'(op);
    bus.z          = zz;
    bus.inst_valid = v;
    bus.stall      = st;
    bus.supervisor = sup;
    bus.irq        = rq;
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit sup;
    int legal_ops[6];
    legal_ops = '{24, 25, 27, 28, 29, 31};

    reset_n = 1'b0;
    set_in(32, 0, 1, 0, 0, 0);
    step(); step();
    chk("rst_state", int'(bus.state_o), 0);
    chk("rst_pc_en", int'(bus.pc_en), 0);
    chk("rst_pcsel", int'(bus.pcsel), 0);
    chk("rst_xp_wr", int'(bus.xp_wr), 0);
    chk("rst_ack", int'(bus.irq_ack), 0);
    chk("rst_illop", int'(bus.illop_cnt), 0);

    // boot hold: two cycles frozen, then PC+4 every cycle
    reset_n = 1'b1;
    #1;
    chk("boot0_state", int'(bus.state_o), 0);
    chk("boot0_pc_en", int'(bus.pc_en), 0);
    step();
    chk("boot1_state", int'(bus.state_o), 0);
    chk("boot1_pc_en", int'(bus.pc_en), 0);
    step();
    chk("run_state", int'(bus.state_o), 1);
    chk("run_pc_en", int'(bus.pc_en), 1);
    chk("run_pcsel", int'(bus.pcsel), 0);
    step();
    chk("run2_pc_en", int'(bus.pc_en), 1);

    // branch decode
    set_in(28, 1, 1, 0, 0, 0); chk("beq_taken", int'(bus.pcsel), 1); step();
    set_in(28, 0, 1, 0, 0, 0); chk("beq_not", int'(bus.pcsel), 0); step();
    set_in(29, 0, 1, 0, 0, 0); chk("bne_taken", int'(bus.pcsel), 1); step();
    set_in(29, 1, 1, 0, 0, 0); chk("bne_not", int'(bus.pcsel), 0); step();
    set_in(27, 0, 1, 0, 0, 0); chk("jmp_sel", int'(bus.pcsel), 2); step();
    chk("branch_state", int'(bus.state_o), 1);

    // illegal opcode trap
    set_in(0, 0, 1, 0, 0, 0);
    chk("ill_pcsel", int'(bus.pcsel), 3);
    chk("ill_xp_wr", int'(bus.xp_wr), 1);
    chk("ill_pc_en", int'(bus.pc_en), 1);
    chk("ill_cnt0", int'(bus.illop_cnt), 0);
    step();
    chk("ill_trap_state", int'(bus.state_o), 3);
    chk("ill_trap_pc_en", int'(bus.pc_en), 0);
    chk("ill_trap_xp_wr", int'(bus.xp_wr), 0);
    chk("ill_cnt1", int'(bus.illop_cnt), 1);
    set_in(32, 0, 1, 0, 0, 0);
    chk("ill_bubble_pc_en", int'(bus.pc_en), 0);
    step();
    chk("ill_back_run", int'(bus.state_o), 1);

    // saturation
    for (int i = 0; i < 300; i++) begin
      set_in(0, 0, 1, 0, 0, 0);
      step(); step();
    end
    chk("ill_saturated", int'(bus.illop_cnt), 255);

    // irq deferred while in supervisor mode
    set_in(32, 0, 1, 0, 1, 1);
    chk("sup_irq_sel", int'(bus.pcsel), 0);
    step();
    for (int i = 0; i < 4; i++) begin
      set_in(32, 0, 1, 0, 1, 0);
      chk("sup_defer_sel", int'(bus.pcsel), 0);
      chk("sup_defer_ack", int'(bus.irq_ack), 0);
      step();
    end
    set_in(32, 0, 1, 0, 0, 0);
    chk("irq_take_sel", int'(bus.pcsel), 4);
    chk("irq_take_xp", int'(bus.xp_wr), 1);
    chk("irq_take_en", int'(bus.pc_en), 1);
    step();
    chk("irq_ack_pulse", int'(bus.irq_ack), 1);
    chk("irq_trap_state", int'(bus.state_o), 3);
    step();
    chk("irq_ack_drop", int'(bus.irq_ack), 0);
    chk("irq_cleared_sel", int'(bus.pcsel), 0);

    // stall with irq raised mid-stall
    set_in(32, 0, 1, 1, 0, 0); chk("stl1_pc_en", int'(bus.pc_en), 0); step();
    chk("stl_state", int'(bus.state_o), 2);
    set_in(32, 0, 1, 1, 0, 1); chk("stl2_pc_en", int'(bus.pc_en), 0); step();
    set_in(32, 0, 1, 1, 0, 0); chk("stl3_pc_en", int'(bus.pc_en), 0); step();
    set_in(32, 0, 1, 0, 0, 0);
    chk("stl_bubble_state", int'(bus.state_o), 2);
    chk("stl_bubble_pc_en", int'(bus.pc_en), 0);
    step();
    chk("stl_irq_sel", int'(bus.pcsel), 4);
    chk("stl_irq_xp", int'(bus.xp_wr), 1);
    step();
    chk("stl_irq_ack", int'(bus.irq_ack), 1);
    step();
    chk("stl_ack_drop", int'(bus.irq_ack), 0);

    // irq and illegal op together: irq wins, counter frozen
    set_in(32, 0, 1, 0, 0, 1); step();
    set_in(0, 0, 1, 0, 0, 0);
    chk("both_sel", int'(bus.pcsel), 4);
    step();
    chk("both_cnt", int'(bus.illop_cnt), 255);
    step();

    // reset mid-TRAP with irq pending
    set_in(0, 0, 1, 0, 0, 1);
    chk("pre_rst_sel", int'(bus.pcsel), 3);
    step();
    chk("pre_rst_trap", int'(bus.state_o), 3);
    set_in(32, 0, 1, 0, 0, 0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_state", int'(bus.state_o), 0);
    chk("mid_rst_pc_en", int'(bus.pc_en), 0);
    chk("mid_rst_pcsel", int'(bus.pcsel), 0);
    chk("mid_rst_xp", int'(bus.xp_wr), 0);
    chk("mid_rst_ack", int'(bus.irq_ack), 0);
    chk("mid_rst_cnt", int'(bus.illop_cnt), 0);
    step(); step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("post_rst_ack", int'(bus.irq_ack), 0);
      step();
    end
    chk("post_rst_state", int'(bus.state_o), 1);
    chk("post_rst_sel", int'(bus.pcsel), 0);

    // randomized traffic
    sup = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      int op;
      int r;
      if ($urandom_range(0, 399) == 0) begin
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) sup = ~sup;
      r = int'($urandom_range(0, 9));
      if (r < 3)      op = int'($urandom_range(0, 63));
      else if (r < 8) op = legal_ops[$urandom_range(0, 5)];
      else            op = int'($urandom_range(32, 63));
      set_in(op, 1'($urandom_range(0, 1)),
             $urandom_range(0, 99) < 85,
             $urandom_range(0, 99) < 15,
             sup,
             $urandom_range(0, 99) < 8);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
